// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - SPI flash to cartridge RAM loader FSM with toggle handshake
// Optional: define ROM_LOADER_CHECKSUM_EN to add an 8-bit running checksum output.
module rom_loader #(
  parameter int a_bits         = 14,
  parameter int amount         = 8192,
  parameter int timeout_cycles = 10000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slot_valid,
  output logic              start,
  input  logic              busy,
  input  logic              req,
  output logic              ack,
  input  logic [a_bits-1:0] a,
  input  logic [7:0]        q,
  output logic [a_bits-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_strobe,
  output logic [a_bits:0]   byte_count,
  output logic              done,
  output logic              error,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              hold_reset
);

  localparam int cw = a_bits + 1;
  localparam int tw = $clog2(timeout_cycles + 1);

  localparam logic [cw-1:0] amount_lim   = cw'(amount);
  localparam logic [cw-1:0] count_one    = cw'(1);
  localparam logic [tw-1:0] timeout_last = tw'(timeout_cycles - 1);
  localparam logic [tw-1:0] tmo_one      = tw'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state;
  logic          slot_prev;
  logic          busy_prev;
  logic          overrun;
  logic [tw-1:0] timeout_cnt;

  logic          slot_rise;
  logic          busy_fall;
  logic          req_pending;
  logic          take_byte;
  logic          overrun_now;
  logic          overrun_after;
  logic [cw-1:0] count_after;

  // A byte taken in the same cycle busy falls must count towards the end-of-load decision,
  // so the decision looks at the post-update count and overrun flag.
  assign slot_rise     = slot_valid & ~slot_prev;
  assign busy_fall     = busy_prev & ~busy;
  assign req_pending   = req ^ ack;
  assign take_byte     = (state == S_LOAD) && req_pending && (byte_count < amount_lim);
  assign overrun_now   = (state == S_LOAD) && req_pending && (byte_count >= amount_lim);
  assign overrun_after = overrun | overrun_now;
  assign count_after   = take_byte ? (byte_count + count_one) : byte_count;

  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign hold_reset = ~done;

  // Edge detectors; cleared by reset so a slot_valid already high at release starts a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_prev <= 1'b0;
      busy_prev <= 1'b0;
    end else begin
      slot_prev <= slot_valid;
      busy_prev <= busy;
    end
  end

  // Main load sequencer; start is high exactly while the FSM sits in START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      start <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (slot_rise) begin
            state <= S_START;
            start <= 1'b1;
          end
        end
        S_START: state <= S_LOAD;
        S_LOAD: begin
          if (busy_fall) begin
            state <= ((count_after == amount_lim) && !overrun_after) ? S_DONE : S_ERR;
          end else if (timeout_cnt == timeout_last) begin
            state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Toggle handshake: every req change is acknowledged in any state, but only LOAD writes RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= take_byte;
      if (req_pending) begin
        ack <= req;
      end
      if (take_byte) begin
        wr_addr <= a;
        wr_data <= q;
      end
    end
  end

  // Per-load bookkeeping: saturating byte count, overrun flag and timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_count  <= '0;
      overrun     <= 1'b0;
      timeout_cnt <= '0;
    end else if (state == S_START) begin
      byte_count  <= '0;
      overrun     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      byte_count <= count_after;
      overrun    <= overrun_after;
      if (state == S_LOAD) begin
        timeout_cnt <= timeout_cnt + tmo_one;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Running modulo-256 sum of written bytes, updated on the same edge that raises wr_strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 8'h00;
    end else if (state == S_START) begin
      checksum <= 8'h00;
    end else if (take_byte) begin
      checksum <= checksum + q;
    end
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader (main loads plus a small timeout instance)
module tb_rom_loader;

  localparam int AB  = 14;
  localparam int AMT = 8192;
  localparam int TMO = 50000;
  localparam int TAB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, slot_valid, busy, req;
  logic [AB-1:0] a;
  logic [7:0]    q;
  logic          start, ack, wr_strobe, done, error, hold_reset;
  logic [AB-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AB:0]   byte_count;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
  logic [7:0]    t_checksum;
`endif

  logic           t_slot, t_busy, t_req;
  logic [TAB-1:0] t_a;
  logic [7:0]     t_q;
  logic           t_start, t_ack, t_wr_strobe, t_done, t_error, t_hold_reset;
  logic [TAB-1:0] t_wr_addr;
  logic [7:0]     t_wr_data;
  logic [TAB:0]   t_byte_count;

  rom_loader #(.a_bits(AB), .amount(AMT), .timeout_cycles(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .slot_valid(slot_valid), .start(start),
    .busy(busy), .req(req), .ack(ack), .a(a), .q(q),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .byte_count(byte_count), .done(done), .error(error),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .hold_reset(hold_reset)
  );

  rom_loader #(.a_bits(TAB), .amount(8), .timeout_cycles(1000)) dut_t (
    .clk(clk), .reset_n(reset_n), .slot_valid(t_slot), .start(t_start),
    .busy(t_busy), .req(t_req), .ack(t_ack), .a(t_a), .q(t_q),
    .wr_addr(t_wr_addr), .wr_data(t_wr_data), .wr_strobe(t_wr_strobe),
    .byte_count(t_byte_count), .done(t_done), .error(t_error),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum(t_checksum),
`endif
    .hold_reset(t_hold_reset)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int start_cnt  = 0;
  int model_tog  = 0;
  logic [AB+7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest byte the model expects to be written.
  always @(negedge clk) begin : monitor
    logic [AB+7:0] e;
    if (start) start_cnt++;
    if (wr_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[AB+7:8]));
        check("wr_data", 64'(wr_data), 64'(e[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte; the model expects a write only while fewer than AMT bytes have arrived.
  task automatic send_byte(input logic [7:0] dv, input bit drop_busy);
    logic [AB-1:0] av;
    av = AB'($urandom);
    a = av;
    q = dv;
    req = ~req;
    if (drop_busy) busy = 1'b0;
    if (model_tog < AMT) exp_q.push_back({av, dv});
    model_tog++;
    step();
  endtask

  task automatic begin_load();
    int s0;
    slot_valid = 1'b0;
    step();
    s0 = start_cnt;
    slot_valid = 1'b1;
    for (int i = 0; i < 10 && !start; i++) step();
    check("start_seen", 64'(start), 64'(1));
    busy = 1'b1;
    model_tog = 0;
    step();
    check("start_one_cycle", 64'(start), 64'(0));
    check("start_pulse_count", 64'(start_cnt - s0), 64'(1));
    check("count_cleared", 64'(byte_count), 64'(0));
  endtask

  task automatic finish_load(input int strobes_before);
    bit exp_done;
    int written;
    busy = 1'b0;
    step();
    step();
    exp_done = (model_tog == AMT);
    written  = (model_tog < AMT) ? model_tog : AMT;
    check("done", 64'(done), 64'(exp_done));
    check("error", 64'(error), 64'(!exp_done));
    check("hold_reset", 64'(hold_reset), 64'(!exp_done));
    check("byte_count", 64'(byte_count), 64'(written));
    check("strobe_total", 64'(strobe_cnt - strobes_before), 64'(written));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int s, n;
    logic [7:0] sum;
    reset_n = 1'b0; slot_valid = 1'b0; busy = 1'b0; req = 1'b0; a = '0; q = '0;
    t_slot = 1'b0; t_busy = 1'b0; t_req = 1'b0; t_a = '0; t_q = '0;
    step(); step();
    check("rst_start", 64'(start), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_addr_data", 64'({wr_addr, wr_data}), 64'(0));
    check("rst_count", 64'(byte_count), 64'(0));
    check("rst_done_error", 64'({done, error}), 64'(0));
    check("rst_hold", 64'(hold_reset), 64'(1));
    reset_n = 1'b1;
    step();

    // Timeout on the small instance: ERR exactly 1000 cycles after entering LOAD.
    t_slot = 1'b1;
    for (int i = 0; i < 10 && !t_start; i++) step();
    check("t_start_seen", 64'(t_start), 64'(1));
    t_busy = 1'b1;
    step();
    n = 0;
    for (int i = 0; i < 1100 && !t_error; i++) begin
      step();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(1000));
    check("timeout_not_done", 64'(t_done), 64'(0));
    t_busy = 1'b0;

    // Full load; the last toggle coincides with busy falling.
    s = strobe_cnt;
    begin_load();
    for (int i = 0; i < AMT - 1; i++) begin
      send_byte(8'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) step();
    end
    send_byte(8'($urandom), 1'b1);
    finish_load(s);

    // Short load: one byte missing.
    s = strobe_cnt;
    begin_load();
    for (int i = 0; i < AMT - 1; i++) send_byte(8'($urandom), 1'b0);
    finish_load(s);

    // Overrun: one toggle too many is acknowledged but not written.
    s = strobe_cnt;
    begin_load();
    for (int i = 0; i < AMT + 1; i++) send_byte(8'($urandom), 1'b0);
    step();
    check("overrun_acked", 64'(ack), 64'(req));
    check("overrun_saturate", 64'(byte_count), 64'(AMT));
    finish_load(s);

`ifdef ROM_LOADER_CHECKSUM_EN
    s = strobe_cnt;
    begin_load();
    sum = 8'h00;
    for (int v = 1; v < 256; v++) begin
      send_byte(8'(v), 1'b0);
      sum = sum + 8'(v);
    end
    send_byte(8'h02, 1'b0);
    sum = sum + 8'h02;
    step();
    check("checksum", 64'(checksum), 64'(sum));
    check("checksum_const", 64'(checksum), 64'(8'h82));
    finish_load(s);
`endif

    // Reset mid-load after 100 bytes with req left mismatched.
    begin_load();
    for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1'b0);
    step();
    req = 1'b1; slot_valid = 1'b0; busy = 1'b0; reset_n = 1'b0;
    step();
    check("midrst_ack", 64'(ack), 64'(0));
    check("midrst_count", 64'(byte_count), 64'(0));
    check("midrst_strobe", 64'(wr_strobe), 64'(0));
    check("midrst_queue", 64'(exp_q.size()), 64'(0));
    s = strobe_cnt;
    reset_n = 1'b1;
    step();
    check("drain_after_reset", 64'(ack), 64'(req));
    step(); step();
    check("no_strobe_after_reset", 64'(strobe_cnt - s), 64'(0));
    s = strobe_cnt;
    begin_load();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
    check("restart_count", 64'(byte_count), 64'(10));
    finish_load(s);

    // Drain in ERR: toggles are acknowledged without writes.
    s = strobe_cnt;
    for (int i = 0; i < 3; i++) begin
      req = ~req;
      step();
      check("drain_err_ack", 64'(ack), 64'(req));
    end
    check("drain_err_no_strobe", 64'(strobe_cnt - s), 64'(0));

    // slot_valid already high at reset release counts as a rising edge.
    reset_n = 1'b0;
    slot_valid = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("start_after_release", 64'(start), 64'(1));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter a_bits, default 14: width of the cartridge ROM write address.
REQ-002 Parameter amount, default 8192: number of bytes a complete load delivers.
REQ-003 Parameter timeout_cycles, default 10000000: maximum clk cycles from start until busy falls.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock (sysclk domain); the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- slot_valid  in  1  flash slot number valid, from the USB controller.
- start  out  1  one-cycle pulse that starts the SPI flash load.
- busy  in  1  high while the SPI flash loader is running.
- req  in  1  toggle from the flash loader: a new byte is presented.
- ack  out  1  toggle acknowledge back to the flash loader.
- a  in  a_bits  byte address from the flash loader.
- q  in  8  byte data from the flash loader.
- wr_addr  out  a_bits  write address to the cartridge block RAM.
- wr_data  out  8  write data to the cartridge block RAM.
- wr_strobe  out  1  one-cycle write enable to the cartridge block RAM.
- byte_count  out  a_bits+1  number of bytes written in the current load.
- done  out  1  a complete load has finished; holds until the next load starts.
- error  out  1  the last load failed.
- hold_reset  out  1  high except in DONE; drives the C64 reset hold.

Function
REQ-005 The block SHALL be an FSM with states IDLE, START, LOAD, DONE and ERR.
REQ-006 In IDLE, DONE and ERR, a rising edge of slot_valid (registered previous value is 0, current value is 1) SHALL move the FSM to START.
REQ-007 START SHALL assert start for exactly one cycle, clear byte_count, the timeout counter and the checksum, and move to LOAD on the next cycle.
REQ-008 Handshake, byte accepted: in LOAD, when req differs from ack and byte_count is less than amount, the block SHALL, in that cycle:
- register a into wr_addr and q into wr_data;
- set ack equal to req;
- increment byte_count.
wr_strobe SHALL be high in the following cycle only.
REQ-009 Only one byte SHALL be accepted per req toggle, and back-to-back toggles SHALL be accepted on consecutive cycles.
REQ-010 Overrun: in LOAD, a req toggle when byte_count equals amount SHALL be acknowledged with no wr_strobe and SHALL set an overrun flag.
REQ-011 Drain: in IDLE, START, DONE and ERR, a req toggle SHALL be acknowledged with no wr_strobe.
REQ-012 Load end: in LOAD, a falling edge of busy SHALL go to DONE if byte_count equals amount and no overrun occurred, and to ERR otherwise.
REQ-013 If busy falls and a req toggle occurs in the same cycle, the byte SHALL be accepted first, and the REQ-012 decision SHALL use the incremented count.
REQ-014 Timeout: in LOAD, the timeout counter SHALL increment every cycle, and reaching timeout_cycles SHALL move the FSM to ERR.
REQ-015 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR; hold_reset SHALL equal not done.
REQ-016 byte_count SHALL saturate at amount and never wrap.

Reset
REQ-017 While reset_n is 0, the block SHALL asynchronously force:
- FSM = IDLE;
- start = 0, ack = 0, wr_strobe = 0;
- wr_addr = 0, wr_data = 0, byte_count = 0;
- done = 0, error = 0, hold_reset = 1;
- timeout counter, overrun flag and checksum cleared;
- previous slot_valid and previous busy registers = 0.
REQ-018 A reset during LOAD SHALL abandon the load, with no further wr_strobe; any pending req mismatch after release SHALL be drained per REQ-011.
REQ-019 If slot_valid is already 1 when reset_n deasserts, this SHALL count as a rising edge and start a load.

Configuration
REQ-020 Macro ROM_LOADER_CHECKSUM_EN, when defined:
- adds output port checksum, 8 bits;
- checksum is the modulo-256 sum of every byte written with wr_strobe in the current load;
- checksum is cleared in START and updated in the same cycle as wr_strobe.
REQ-021 When ROM_LOADER_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Normal load, amount=8192: slot_valid 0->1 -> start pulses once; 8192 toggles each produce wr_strobe one cycle later with matching addr/data; busy falls -> done=1, hold_reset=0, byte_count=8192.
REQ-023 Short load: busy falls after 8191 bytes -> error=1, done=0, hold_reset=1.
REQ-024 Overrun: 8193 toggles, then busy falls -> 8192 wr_strobe pulses, last toggle acked, error=1.
REQ-025 Timeout, timeout_cycles=1000: busy stays high -> ERR exactly 1000 cycles after entering LOAD.
REQ-026 Reset mid-load after 100 bytes, with req mismatched at release:
- no wr_strobe after reset;
- ack equals req within 1 cycle;
- a slot_valid re-edge restarts the load from byte_count=0.
REQ-027 With ROM_LOADER_CHECKSUM_EN defined: bytes 0x01..0xFF then 0x02 -> checksum=0x82.
